mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
// Shares the single memory_fpga port between the CPU (my_chip) and the UART host loader/dumper.
// The CPU owns the bus by default. A host request holds the CPU in reset, takes the bus and
// sequences the memory's multi-beat write/read protocol, or sweeps all 1024 words to zero.
// Sits between my_chip, memory_fpga and the UART command decoder in cpu_on_fpga.
// PARAMETERS
// AW      10  address / addr_data bus width
// DW      12  memory word width (two 6-bit halves)
// RD_LAT  1   cycles from last read beat to valid mem_result
// PORTS
// clk              in   1   system clock
// rst              in   1   asynchronous reset, active high
// cpu_addr_data    in   AW  CPU bus addr/data
// cpu_read_write   in   1   CPU bus read_write
// cpu_write_commit in   1   CPU bus write_commit
// cpu_hold         out  1   reset to my_chip (high while host owns bus)
// host_req         in   1   host wants the bus; held high for whole host session
// host_cmd_valid   in   1   one-cycle command strobe (ignored unless host_cmd_ready)
// host_cmd         in   2   0=read, 1=write, 2=clear-all, 3=reserved (ignored)
// host_addr        in   AW  word address
// host_wdata       in   DW  write data
// host_cmd_ready   out  1   arbiter idle in host mode, can accept a command
// host_rdata       out  DW  read result
// host_rvalid      out  1   one-cycle pulse, host_rdata valid
// host_busy        out  1   high from command accept through completion
// mem_addr_data    out  AW  to memory_fpga
// mem_read_write   out  1   to memory_fpga
// mem_write_commit out  1   to memory_fpga
// mem_result       in   DW  from memory_fpga
// BEHAVIOUR
// - Reset: state CPU_RUN; cpu_hold=1 (CPU held while rst high, released first cycle after),
//   host_cmd_ready=0, host_rvalid=0, host_busy=0, host_rdata=0, clear counter=0.
// - CPU_RUN: mem_* = cpu_* combinationally (zero latency); cpu_hold=0. host_req -> SWITCH.
// - SWITCH: cpu_hold=1, mem_* driven 0 (idle) for one cycle -> HOST_IDLE.
// - HOST_IDLE: cpu_hold=1, mem_* idle, host_cmd_ready=1. !host_req -> CPU_RUN (cpu_hold drops
//   next cycle; CPU restarts from reset). host_cmd_valid: latch addr/wdata/cmd, host_busy=1.
// - Write (4 beats, one cycle each, read_write=1 on all):
//   W_AL addr_data=addr, commit=0; W_DL addr_data={4'b0,wdata[5:0]}, commit=1;
//   W_AU addr_data=addr, commit=0; W_DU addr_data={4'b0,wdata[11:6]}, commit=1 -> HOST_IDLE.
// - Read: R_ADDR addr_data=addr, read_write=0, commit=0; R_WAIT counts RD_LAT cycles, then
//   host_rdata<=mem_result, host_rvalid pulse 1 cycle -> HOST_IDLE.
// - Clear: counter 0..1023, each address runs the 4-beat write with data 0; after addr 0x3FF
//   counter wraps to 0, -> HOST_IDLE. Total 4096 cycles.
// - host_busy deasserts in the cycle the FSM re-enters HOST_IDLE.
// - host_req dropped mid-command: command completes; return to CPU_RUN only from HOST_IDLE.
// - host_cmd_valid while not ready, or cmd=3: ignored, no state change.
// - rst mid-operation: abort immediately, CPU_RUN with cpu_hold=1 until rst falls; no partial
//   beat is replayed.
// - Never drive read_write=1 and write_commit=1 from the CPU path while cpu_hold=1 (halt code).
// STRUCTURE
// - Shared package mem_bus_pkg: state enum (CPU_RUN, SWITCH, HOST_IDLE, W_AL, W_DL, W_AU,
//   W_DU, R_ADDR, R_WAIT, CLR), host_cmd encodings, AW/DW defaults.
// - One sub-module: mem_write_seq (4-beat write sequencer, start/addr/data in, done out),
//   shared by write and clear paths. Mux and FSM in the top.
// TESTING
// - Reset, host_req=0, CPU drives addr_data=0x155, rw=1, commit=0 -> mem_* identical same cycle, cpu_hold=0.
// - host_req=1 -> cpu_hold=1 next cycle, host_cmd_ready=1 two cycles after request.
// - Write addr 0x2A5 data 0xABC -> beats 0x2A5/c0, 0x03C/c1, 0x2A5/c0, 0x02A/c1; busy 4 cycles.
// - Read addr 0x2A5 (model returns 0xABC) -> host_rvalid pulse 1+RD_LAT cycles after accept, rdata=0xABC.
// - Clear -> 4096 beats, last addr 0x3FF, busy drops after; host_req=0 -> cpu_hold=0 next cycle.
// - rst asserted during W_DL -> mem_* idle immediately, cpu_hold=1, CPU_RUN after release.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: arbiter states, host command codes and default widths shared by the memory bus arbiter
package mem_bus_pkg;
    localparam int AW_DEF     = 10;
    localparam int DW_DEF     = 12;
    localparam int RD_LAT_DEF = 1;

    typedef enum logic [3:0] {
        CPU_RUN, SWITCH, HOST_IDLE, W_AL, W_DL, W_AU, W_DU, R_ADDR, R_WAIT, CLR
    } state_t;

    typedef enum logic [1:0] {
        CMD_READ  = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_CLEAR = 2'd2,
        CMD_RSVD  = 2'd3
    } host_cmd_t;
endpackage

// File: rtl/mem_write_seq.sv
// mem_write_seq: drives one word onto memory_fpga as addr/low-half then addr/high-half write beats
module mem_write_seq
    import mem_bus_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data,
    output logic [AW-1:0] addr_data,
    output logic          commit,
    output logic          active,
    output logic          done
);
    localparam int HW = DW / 2;

    logic [1:0] beat;

    // a start in the done cycle chains the next word with no gap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            beat   <= 2'd0;
        end else begin
            active <= start || (active && !done);
            beat   <= active ? beat + 2'd1 : 2'd0;
        end
    end

    assign done      = active && beat == 2'd3;
    assign commit    = active && beat[0];
    assign addr_data = !active ? '0 : !beat[0] ? addr : beat[1] ? AW'(data[DW-1:HW]) : AW'(data[HW-1:0]);
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares memory_fpga between the CPU and the UART host loader, holding the CPU in reset while the host owns the bus
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] cpu_addr_data,
    input  logic          cpu_read_write,
    input  logic          cpu_write_commit,
    output logic          cpu_hold,
    input  logic          host_req,
    input  logic          host_cmd_valid,
    input  logic [1:0]    host_cmd,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_cmd_ready,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    output logic          host_busy,
    output logic [AW-1:0] mem_addr_data,
    output logic          mem_read_write,
    output logic          mem_write_commit,
    input  logic [DW-1:0] mem_result
);
    localparam int LW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;

    state_t        state, state_nxt;
    logic [AW-1:0] addr_q, clr_cnt, seq_addr, seq_addr_data;
    logic [DW-1:0] wdata_q, seq_data;
    logic [LW-1:0] wait_cnt;
    logic          accept, start, rd_done, clr_last;
    logic          seq_commit, seq_active, seq_done;

    assign accept   = state == HOST_IDLE && host_req && host_cmd_valid && host_cmd != CMD_RSVD;
    assign rd_done  = wait_cnt == LW'(RD_LAT - 1);
    assign clr_last = clr_cnt == '1;
    assign seq_addr = state == CLR ? clr_cnt : addr_q;
    assign seq_data = state == CLR ? {DW{1'b0}} : wdata_q;

    mem_write_seq #(.AW(AW), .DW(DW)) u_seq (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .addr     (seq_addr),
        .data     (seq_data),
        .addr_data(seq_addr_data),
        .commit   (seq_commit),
        .active   (seq_active),
        .done     (seq_done)
    );

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        unique case (state)
            CPU_RUN:   state_nxt = host_req ? SWITCH : CPU_RUN;
            SWITCH:    state_nxt = HOST_IDLE;
            HOST_IDLE: begin
                state_nxt = !host_req ? CPU_RUN : !accept ? HOST_IDLE :
                            host_cmd == CMD_READ ? R_ADDR : host_cmd == CMD_WRITE ? W_AL : CLR;
                start     = accept && host_cmd != CMD_READ;
            end
            W_AL:      state_nxt = W_DL;
            W_DL:      state_nxt = W_AU;
            W_AU:      state_nxt = W_DU;
            W_DU:      state_nxt = HOST_IDLE;
            R_ADDR:    state_nxt = R_WAIT;
            R_WAIT:    state_nxt = rd_done ? HOST_IDLE : R_WAIT;
            CLR: begin
                state_nxt = seq_done && clr_last ? HOST_IDLE : CLR;
                start     = seq_done && !clr_last;
            end
            default:   state_nxt = CPU_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= CPU_RUN;
            addr_q      <= '0;
            wdata_q     <= '0;
            clr_cnt     <= '0;
            wait_cnt    <= '0;
            host_rdata  <= '0;
            host_rvalid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q  <= host_addr;
                wdata_q <= host_wdata;
            end
            if (state == CLR && seq_done)
                clr_cnt <= clr_cnt + AW'(1);
            wait_cnt    <= state == R_WAIT ? wait_cnt + LW'(1) : '0;
            host_rvalid <= state == R_WAIT && rd_done;
            if (state == R_WAIT && rd_done)
                host_rdata <= mem_result;
        end
    end

    // rst gates the CPU path combinationally so a held CPU can never reach the memory
    assign cpu_hold         = rst || state != CPU_RUN;
    assign host_cmd_ready   = state == HOST_IDLE;
    assign host_busy        = !(state inside {CPU_RUN, SWITCH, HOST_IDLE});
    assign mem_addr_data    = !cpu_hold ? cpu_addr_data : state == R_ADDR ? addr_q : seq_addr_data;
    assign mem_read_write   = !cpu_hold ? cpu_read_write : seq_active;
    assign mem_write_commit = !cpu_hold ? cpu_write_commit : seq_commit;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: random CPU/host traffic checked every cycle against a transaction-level bus model
module tb_mem_bus_arbiter;
    localparam int AW = 10, DW = 12, RD_LAT = 1;

    logic          clk = 1'b0, rst = 1'b1;
    logic [AW-1:0] cpu_addr_data = '0;
    logic          cpu_read_write = 1'b0, cpu_write_commit = 1'b0;
    logic          cpu_hold;
    logic          host_req = 1'b0, host_cmd_valid = 1'b0;
    logic [1:0]    host_cmd = 2'd0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_cmd_ready, host_rvalid, host_busy;
    logic [DW-1:0] host_rdata, mem_result;
    logic [AW-1:0] mem_addr_data;
    logic          mem_read_write, mem_write_commit;
    int            n_total = 0, n_pass = 0;
    logic          started = 1'b0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .cpu_addr_data(cpu_addr_data), .cpu_read_write(cpu_read_write),
        .cpu_write_commit(cpu_write_commit), .cpu_hold(cpu_hold),
        .host_req(host_req), .host_cmd_valid(host_cmd_valid), .host_cmd(host_cmd),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_cmd_ready(host_cmd_ready),
        .host_rdata(host_rdata), .host_rvalid(host_rvalid), .host_busy(host_busy),
        .mem_addr_data(mem_addr_data), .mem_read_write(mem_read_write),
        .mem_write_commit(mem_write_commit), .mem_result(mem_result)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    // memory_fpga stand-in: address beat then half-word commit, low half first
    logic [DW-1:0] smem [1024];
    logic [AW-1:0] s_addr = '0, s_raddr = '0;
    logic          s_hi = 1'b0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s_hi <= 1'b0;
            for (int i = 0; i < 1024; i++) smem[i] <= '0;
        end else if (cpu_hold) begin
            if (!mem_read_write) s_raddr <= mem_addr_data;
            else if (!mem_write_commit) s_addr <= mem_addr_data;
            else begin
                if (s_hi) smem[s_addr][11:6] <= mem_addr_data[5:0];
                else smem[s_addr][5:0] <= mem_addr_data[5:0];
                s_hi <= !s_hi;
            end
        end
    end
    assign mem_result = smem[s_raddr];

    // reference model: bus ownership phase plus a script of host-side cycles still to come
    typedef struct packed {
        logic [AW-1:0] ad;
        logic          rw;
        logic          wc;
        logic          fin;
        logic [DW-1:0] rd;
    } beat_t;
    beat_t         script[$];
    beat_t         popped;
    int            phase;
    logic [DW-1:0] mem_m [1024];
    logic          exp_rv;
    logic [DW-1:0] exp_rd;

    function automatic beat_t bt(logic [AW-1:0] ad, logic rw, logic wc, logic fin, logic [DW-1:0] rd);
        return {ad, rw, wc, fin, rd};
    endfunction

    task automatic push_write(logic [AW-1:0] a, logic [DW-1:0] d);
        script.push_back(bt(a, 1'b1, 1'b0, 1'b0, '0));
        script.push_back(bt(AW'(d[5:0]), 1'b1, 1'b1, 1'b0, '0));
        script.push_back(bt(a, 1'b1, 1'b0, 1'b0, '0));
        script.push_back(bt(AW'(d[11:6]), 1'b1, 1'b1, 1'b0, '0));
        mem_m[a] = d;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            script.delete();
            phase  = 0;
            exp_rv = 1'b0;
            exp_rd = '0;
            for (int i = 0; i < 1024; i++) mem_m[i] = '0;
        end else begin
            exp_rv = 1'b0;
            if (script.size() != 0) begin
                popped = script.pop_front();
                if (popped.fin) begin
                    exp_rv = 1'b1;
                    exp_rd = popped.rd;
                end
            end else if (phase == 0) phase = host_req ? 1 : 0;
            else if (phase == 1) phase = 2;
            else if (!host_req) phase = 0;
            else if (host_cmd_valid && host_cmd == 2'd0) begin
                script.push_back(bt(host_addr, 1'b0, 1'b0, 1'b0, '0));
                for (int i = 0; i < RD_LAT; i++)
                    script.push_back(bt('0, 1'b0, 1'b0, i == RD_LAT - 1, mem_m[host_addr]));
            end else if (host_cmd_valid && host_cmd == 2'd1) push_write(host_addr, host_wdata);
            else if (host_cmd_valid && host_cmd == 2'd2)
                for (int i = 0; i < 1024; i++) push_write(AW'(i), '0);
        end
    end

    logic          eh, erw, ewc;
    logic [AW-1:0] ead;
    always @(negedge clk) begin
        if (started) begin
            eh = rst || phase != 0;
            if (!eh) {ead, erw, ewc} = {cpu_addr_data, cpu_read_write, cpu_write_commit};
            else if (script.size() != 0) {ead, erw, ewc} = {script[0].ad, script[0].rw, script[0].wc};
            else {ead, erw, ewc} = '0;
            chk("cycle",
                {cpu_hold, host_cmd_ready, host_busy, host_rvalid, host_rdata, mem_addr_data, mem_read_write, mem_write_commit},
                {eh, !rst && phase == 2 && script.size() == 0, script.size() != 0, exp_rv, exp_rd, ead, erw, ewc});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        cpu_addr_data    = AW'($urandom);
        cpu_read_write   = 1'($urandom);
        cpu_write_commit = 1'($urandom);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!host_cmd_ready && n < 50) begin
            step();
            n++;
        end
        chk("ready_wait", 32'(host_cmd_ready), 32'd1);
    endtask

    task automatic issue(logic [1:0] c, logic [AW-1:0] a, logic [DW-1:0] d);
        host_cmd       = c;
        host_addr      = a;
        host_wdata     = d;
        host_cmd_valid = 1'b1;
        step();
        host_cmd_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        started = 1'b1;
    end

    initial begin
        logic [AW-1:0] wad [4];
        logic          wwc [4];
        logic [AW-1:0] wexp [4];
        logic [AW-1:0] last_ad;
        int            busy_n, commits;
        wexp = '{10'h2A5, 10'h03C, 10'h2A5, 10'h02A};
        repeat (3) step();
        #1;
        chk("reset_state", {cpu_hold, host_cmd_ready, host_busy, host_rvalid, host_rdata}, {1'b1, 1'b0, 1'b0, 1'b0, 12'h000});
        rst = 1'b0;
        cpu_addr_data = 10'h155;
        cpu_read_write = 1'b1;
        cpu_write_commit = 1'b0;
        #1;
        chk("cpu_pass", {mem_addr_data, mem_read_write, mem_write_commit, cpu_hold}, {10'h155, 1'b1, 1'b0, 1'b0});
        repeat (20) step();
        host_req = 1'b1;
        step();
        chk("hold_after_req", {cpu_hold, host_cmd_ready}, 2'b10);
        step();
        chk("ready_after_req", 32'(host_cmd_ready), 32'd1);
        issue(2'd1, 10'h2A5, 12'hABC);
        busy_n = 0;
        for (int i = 0; i < 4; i++) begin
            wad[i] = mem_addr_data;
            wwc[i] = mem_write_commit;
            busy_n += int'(host_busy);
            step();
        end
        for (int i = 0; i < 4; i++) chk($sformatf("w_beat%0d", i), {wad[i], wwc[i]}, {wexp[i], i[0]});
        chk("w_busy_cycles", busy_n, 4);
        chk("w_back_idle", {host_busy, host_cmd_ready}, 2'b01);
        issue(2'd0, 10'h2A5, '0);
        chk("r_rvalid_early0", 32'(host_rvalid), 32'd0);
        step();
        chk("r_rvalid_early1", 32'(host_rvalid), 32'd0);
        step();
        chk("r_rvalid", {host_rvalid, host_rdata}, {1'b1, 12'hABC});
        step();
        chk("r_pulse_end", 32'(host_rvalid), 32'd0);
        for (int i = 0; i < 400; i++) begin
            host_req       = $urandom_range(0, 15) != 0;
            host_cmd_valid = $urandom_range(0, 2) == 0;
            host_cmd       = 2'($urandom_range(0, 2));
            if (host_cmd == 2'd2) host_cmd = 2'd3;
            host_addr      = $urandom_range(0, 3) == 0 ? AW'($urandom) : AW'($urandom_range(0, 7));
            host_wdata     = DW'($urandom);
            step();
        end
        host_cmd_valid = 1'b0;
        host_req = 1'b1;
        wait_ready();
        issue(2'd2, '0, '0);
        busy_n = 0;
        commits = 0;
        last_ad = '0;
        while (host_busy && busy_n < 5000) begin
            busy_n++;
            if (mem_write_commit) commits++;
            else last_ad = mem_addr_data;
            step();
        end
        chk("clr_busy_cycles", busy_n, 4096);
        chk("clr_commits", commits, 2048);
        chk("clr_last_addr", 32'(last_ad), 32'h3FF);
        issue(2'd0, 10'h2A5, '0);
        step();
        step();
        chk("clr_read_zero", {host_rvalid, host_rdata}, {1'b1, 12'h000});
        host_req = 1'b0;
        step();
        chk("hold_release", 32'(cpu_hold), 32'd0);
        host_req = 1'b1;
        wait_ready();
        issue(2'd1, 10'h111, 12'h555);
        step();
        chk("pre_rst_wdl", {mem_addr_data, mem_write_commit}, {10'h015, 1'b1});
        rst = 1'b1;
        host_req = 1'b0;
        #1;
        chk("rst_idle", {mem_addr_data, mem_read_write, mem_write_commit, cpu_hold}, {10'h000, 1'b0, 1'b0, 1'b1});
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_release", 32'(cpu_hold), 32'd0);
        repeat (5) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
